// File: rtl/vga_multi_square_bounce_pkg.sv
// rtl/vga_multi_square_bounce_pkg.sv - shared constants, palette and axis step helper
package vga_multi_square_bounce_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam logic [11:0] BG_COLOUR = 12'h137;

    typedef struct packed {
        logic       bounced;
        logic       dir;
        logic [9:0] pos;
    } axis_t;

    function automatic logic [11:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    return 12'hF00;
            3'd1:    return 12'h0F0;
            3'd2:    return 12'h00F;
            3'd3:    return 12'hFF0;
            3'd4:    return 12'h0FF;
            3'd5:    return 12'hF0F;
            3'd6:    return 12'hFFF;
            default: return 12'hF80;
        endcase
    endfunction

    // One axis of motion; dir 0 = towards increasing coordinate. 11-bit sums never wrap.
    function automatic axis_t axis_step(input logic [9:0] pos, input logic dir,
                                        input logic [3:0] spd, input int res, input int size);
        logic [10:0] p;
        logic [10:0] s;
        axis_t r;
        p = {1'b0, pos};
        s = {7'd0, spd};
        if (!dir) begin
            if (p + 11'(size) + s >= 11'(res)) r = '{bounced: 1'b1, dir: 1'b1, pos: 10'(res - size)};
            else                               r = '{bounced: 1'b0, dir: 1'b0, pos: 10'(p + s)};
        end else begin
            if (p < s) r = '{bounced: 1'b1, dir: 1'b0, pos: 10'd0};
            else       r = '{bounced: 1'b0, dir: 1'b1, pos: 10'(p - s)};
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_multi_square_bounce_if.sv
// rtl/vga_multi_square_bounce_if.sv - pixel coordinate in, paint and bounce event out
interface vga_multi_square_bounce_if;
    logic [9:0] sx;
    logic [9:0] sy;
    logic [3:0] speed;
    logic       pause;
    logic [3:0] paint_r;
    logic [3:0] paint_g;
    logic [3:0] paint_b;
    logic       bounce;

    modport master (output sx, sy, speed, pause, input paint_r, paint_g, paint_b, bounce);
    modport slave  (input sx, sy, speed, pause, output paint_r, paint_g, paint_b, bounce);
endinterface

// File: rtl/vga_multi_square_bounce_mover.sv
// rtl/vga_multi_square_bounce_mover.sv - one square's position, direction and colour index
module vga_multi_square_bounce_mover
    import vga_multi_square_bounce_pkg::*;
#(
    parameter int         H_RES    = H_RES_DEF,
    parameter int         V_RES    = V_RES_DEF,
    parameter int         SQ_SIZE  = 32,
    parameter logic [9:0] START_X  = 10'd0,
    parameter logic [9:0] START_Y  = 10'd0,
    parameter logic [2:0] COL_INIT = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       update,
    input  logic [3:0] speed,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [2:0] col,
    output logic       hit
);

    logic  dir_x;
    logic  dir_y;
    axis_t ax;
    axis_t ay;

    always_comb begin
        ax = axis_step(x, dir_x, speed, H_RES, SQ_SIZE);
        ay = axis_step(y, dir_y, speed, V_RES, SQ_SIZE);
    end

    // speed 0 must not bounce a square resting on an edge, so it gates the whole update
    always_ff @(posedge clk) begin
        if (rst) begin
            x     <= START_X;
            y     <= START_Y;
            dir_x <= 1'b0;
            dir_y <= 1'b0;
            col   <= COL_INIT;
            hit   <= 1'b0;
        end else begin
            hit <= 1'b0;
            if (update && speed != 4'd0) begin
                x     <= ax.pos;
                y     <= ay.pos;
                dir_x <= ax.dir;
                dir_y <= ay.dir;
                if (ax.bounced || ay.bounced) begin
                    col <= col + 3'd1;
                    hit <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_multi_square_bounce.sv
// rtl/vga_multi_square_bounce.sv - N bouncing squares with priority paint mux and frame divider
module vga_multi_square_bounce
    import vga_multi_square_bounce_pkg::*;
#(
    parameter int                  H_RES     = H_RES_DEF,
    parameter int                  V_RES     = V_RES_DEF,
    parameter int                  N_SQ      = 4,
    parameter int                  SQ_SIZE   = 32,
    parameter int                  FRAME_DIV = 1,
    parameter logic [N_SQ*10-1:0]  START_X   = '0,
    parameter logic [N_SQ*10-1:0]  START_Y   = '0
) (
    input logic                    clk,
    input logic                    rst,
    vga_multi_square_bounce_if.slave bus
);

    localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [CW-1:0]   frame_cnt;
    logic            new_frame;
    logic            update;
    logic [9:0]      sq_x   [N_SQ];
    logic [9:0]      sq_y   [N_SQ];
    logic [2:0]      sq_col [N_SQ];
    logic [N_SQ-1:0] sq_hit;
    logic [11:0]     colour;
    logic            blank;

    assign new_frame = (bus.sy == 10'(V_RES)) && (bus.sx == 10'd0);
    assign update    = new_frame && (frame_cnt == '0) && !bus.pause;

    // pause freezes motion only; the divider keeps counting frames
    always_ff @(posedge clk) begin
        if (rst)            frame_cnt <= '0;
        else if (new_frame) frame_cnt <= (frame_cnt == CW'(FRAME_DIV - 1)) ? '0 : frame_cnt + CW'(1);
    end

    for (genvar i = 0; i < N_SQ; i++) begin : g_sq
        vga_multi_square_bounce_mover #(
            .H_RES    (H_RES),
            .V_RES    (V_RES),
            .SQ_SIZE  (SQ_SIZE),
            .START_X  (START_X[10*i +: 10]),
            .START_Y  (START_Y[10*i +: 10]),
            .COL_INIT (3'(i % 8))
        ) u_mover (
            .clk    (clk),
            .rst    (rst),
            .update (update),
            .speed  (bus.speed),
            .x      (sq_x[i]),
            .y      (sq_y[i]),
            .col    (sq_col[i]),
            .hit    (sq_hit[i])
        );
    end

    // Scan from the highest index down so the lowest covering square wins
    always_comb begin
        colour = BG_COLOUR;
        for (int i = N_SQ - 1; i >= 0; i--) begin
            if ({1'b0, bus.sx} >= {1'b0, sq_x[i]} && {1'b0, bus.sx} < {1'b0, sq_x[i]} + 11'(SQ_SIZE) &&
                {1'b0, bus.sy} >= {1'b0, sq_y[i]} && {1'b0, bus.sy} < {1'b0, sq_y[i]} + 11'(SQ_SIZE))
                colour = palette(sq_col[i]);
        end
    end

    assign blank = (bus.sx >= 10'(H_RES)) || (bus.sy >= 10'(V_RES));

    always_ff @(posedge clk) begin
        if (rst || blank) begin
            bus.paint_r <= 4'd0;
            bus.paint_g <= 4'd0;
            bus.paint_b <= 4'd0;
        end else begin
            bus.paint_r <= colour[11:8];
            bus.paint_g <= colour[7:4];
            bus.paint_b <= colour[3:0];
        end
    end

    assign bus.bounce = |sq_hit;

endmodule

// File: tb/tb_vga_multi_square_bounce.sv
// tb/tb_vga_multi_square_bounce.sv - directed table and sequence checks for vga_multi_square_bounce
module tb_vga_multi_square_bounce;

    localparam int A = 0, B = 1, P = 2, D = 3;
    localparam logic [11:0] BG = 12'h137;

    logic       clk;
    logic       rst;
    logic [9:0] sx;
    logic [9:0] sy;
    logic [3:0] spd [4];
    logic       pse [4];
    logic [11:0] pix [4];
    logic       bnc [4];
    logic       bn_now [4];
    logic       bn_after [4];
    int         checks;
    int         errors;

    vga_multi_square_bounce_if if_a();
    vga_multi_square_bounce_if if_b();
    vga_multi_square_bounce_if if_p();
    vga_multi_square_bounce_if if_d();

    assign if_a.sx = sx; assign if_a.sy = sy; assign if_a.speed = spd[A]; assign if_a.pause = pse[A];
    assign if_b.sx = sx; assign if_b.sy = sy; assign if_b.speed = spd[B]; assign if_b.pause = pse[B];
    assign if_p.sx = sx; assign if_p.sy = sy; assign if_p.speed = spd[P]; assign if_p.pause = pse[P];
    assign if_d.sx = sx; assign if_d.sy = sy; assign if_d.speed = spd[D]; assign if_d.pause = pse[D];

    assign pix[A] = {if_a.paint_r, if_a.paint_g, if_a.paint_b};
    assign pix[B] = {if_b.paint_r, if_b.paint_g, if_b.paint_b};
    assign pix[P] = {if_p.paint_r, if_p.paint_g, if_p.paint_b};
    assign pix[D] = {if_d.paint_r, if_d.paint_g, if_d.paint_b};
    assign bnc[A] = if_a.bounce;
    assign bnc[B] = if_b.bounce;
    assign bnc[P] = if_p.bounce;
    assign bnc[D] = if_d.bounce;

    vga_multi_square_bounce #(.N_SQ(2), .START_X({10'd100, 10'd0}), .START_Y({10'd0, 10'd0}))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    vga_multi_square_bounce #(.N_SQ(2), .START_X({10'd606, 10'd606}), .START_Y({10'd446, 10'd100}))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    vga_multi_square_bounce #(.N_SQ(2), .START_X({10'd50, 10'd50}), .START_Y({10'd50, 10'd50}))
        dut_p (.clk(clk), .rst(rst), .bus(if_p));
    vga_multi_square_bounce #(.N_SQ(1), .FRAME_DIV(3))
        dut_d (.clk(clk), .rst(rst), .bus(if_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] exp;
        string       name;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic probe(input int k, input logic [9:0] x, input logic [9:0] y,
                         input logic [11:0] exp, input string name);
        @(negedge clk);
        sx = x;
        sy = y;
        @(posedge clk);
        #1;
        check(name, pix[k], exp);
    endtask

    task automatic do_frame();
        @(negedge clk);
        sx = 10'd0;
        sy = 10'd480;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) bn_now[k] = bnc[k];
        @(negedge clk);
        sx = 10'd700;
        sy = 10'd0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) bn_after[k] = bnc[k];
    endtask

    task automatic set_speeds(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
        spd[A] = a;
        spd[B] = b;
        spd[P] = 4'd0;
        spd[D] = d;
    endtask

    initial begin
        logic any_bounce;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        sx = 10'd0;
        sy = 10'd0;
        for (int k = 0; k < 4; k++) begin
            spd[k] = 4'd0;
            pse[k] = 1'b0;
        end

        tbl[0]  = '{10'd0,   10'd0,   12'hF00, "a_sq0_origin"};
        tbl[1]  = '{10'd31,  10'd31,  12'hF00, "a_sq0_far_corner"};
        tbl[2]  = '{10'd32,  10'd0,   BG,      "a_sq0_right_edge"};
        tbl[3]  = '{10'd0,   10'd32,  BG,      "a_sq0_bottom_edge"};
        tbl[4]  = '{10'd100, 10'd0,   12'h0F0, "a_sq1_origin"};
        tbl[5]  = '{10'd131, 10'd31,  12'h0F0, "a_sq1_far_corner"};
        tbl[6]  = '{10'd132, 10'd0,   BG,      "a_sq1_right_edge"};
        tbl[7]  = '{10'd99,  10'd0,   BG,      "a_sq1_left_edge"};
        tbl[8]  = '{10'd700, 10'd0,   12'h000, "a_hblank"};
        tbl[9]  = '{10'd5,   10'd480, 12'h000, "a_vblank"};
        tbl[10] = '{10'd639, 10'd479, BG,      "a_last_pixel"};

        repeat (3) @(posedge clk);
        probe(A, 10'd0, 10'd0, 12'h000, "a_paint_in_rst");
        probe(P, 10'd60, 10'd60, 12'h000, "p_paint_in_rst");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) probe(A, tbl[i].x, tbl[i].y, tbl[i].exp, tbl[i].name);

        // first frame after reset: a and d move by 2
        set_speeds(4'd2, 4'd0, 4'd2);
        do_frame();
        check("a_bounce_frame1", {11'd0, bn_now[A]}, 12'd0);
        set_speeds(4'd0, 4'd0, 4'd2);
        probe(A, 10'd2,   10'd2,  12'hF00, "a_sq0_at_2_2");
        probe(A, 10'd1,   10'd2,  BG,      "a_sq0_left_of_2");
        probe(A, 10'd2,   10'd1,  BG,      "a_sq0_above_2");
        probe(A, 10'd33,  10'd33, 12'hF00, "a_sq0_far_33");
        probe(A, 10'd34,  10'd2,  BG,      "a_sq0_right_34");
        probe(A, 10'd102, 10'd2,  12'h0F0, "a_sq1_at_102_2");
        probe(A, 10'd101, 10'd2,  BG,      "a_sq1_left_of_102");
        probe(A, 10'd134, 10'd2,  BG,      "a_sq1_right_134");
        probe(D, 10'd2,   10'd2,  12'hF00, "d_frame0_moved");
        probe(D, 10'd1,   10'd2,  BG,      "d_frame0_left");

        // divider 3 with pause across frame 3
        for (int f = 1; f <= 6; f++) begin
            pse[D] = (f == 3);
            do_frame();
            if (f == 2 || f == 3 || f == 5) begin
                probe(D, 10'd2, 10'd2, 12'hF00, $sformatf("d_frame%0d_hold", f));
                probe(D, 10'd1, 10'd2, BG,      $sformatf("d_frame%0d_hold_left", f));
            end
        end
        pse[D] = 1'b0;
        probe(D, 10'd4, 10'd4, 12'hF00, "d_frame6_moved");
        probe(D, 10'd3, 10'd4, BG,      "d_frame6_left");

        // right wall (sq0) and corner (sq1) in one update
        set_speeds(4'd0, 4'd4, 4'd0);
        do_frame();
        check("b_bounce_pulse",  {11'd0, bn_now[B]},   12'd1);
        check("b_bounce_clears", {11'd0, bn_after[B]}, 12'd0);
        probe(B, 10'd608, 10'd104, 12'h0F0, "b_wall_x608_col1");
        probe(B, 10'd607, 10'd104, BG,      "b_wall_left_607");
        probe(B, 10'd639, 10'd104, 12'h0F0, "b_wall_right_639");
        probe(B, 10'd608, 10'd103, BG,      "b_wall_above_103");
        probe(B, 10'd608, 10'd448, 12'h00F, "b_corner_col2");
        probe(B, 10'd607, 10'd448, BG,      "b_corner_left_607");
        probe(B, 10'd608, 10'd447, BG,      "b_corner_above_447");
        probe(B, 10'd639, 10'd479, 12'h00F, "b_corner_last_px");
        do_frame();
        check("b_no_bounce_return", {11'd0, bn_now[B]}, 12'd0);
        probe(B, 10'd604, 10'd108, 12'h0F0, "b_sq0_back_604");
        probe(B, 10'd603, 10'd108, BG,      "b_sq0_left_603");
        probe(B, 10'd604, 10'd107, BG,      "b_sq0_above_107");
        probe(B, 10'd604, 10'd444, 12'h00F, "b_sq1_up_444");
        probe(B, 10'd603, 10'd444, BG,      "b_sq1_left_603");
        probe(B, 10'd604, 10'd443, BG,      "b_sq1_above_443");

        // overlap priority and one-clock latency
        probe(P, 10'd60, 10'd60, 12'hF00, "p_overlap_low_idx");
        sx = 10'd0;
        sy = 10'd0;
        #2;
        check("p_latency_hold", pix[P], 12'hF00);
        @(posedge clk);
        #1;
        check("p_latency_bg", pix[P], BG);
        probe(P, 10'd81,  10'd81, 12'hF00, "p_far_corner");
        probe(P, 10'd82,  10'd50, BG,      "p_right_edge");
        probe(P, 10'd700, 10'd60, 12'h000, "p_blank_700");

        // speed 0 while resting on the wall
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_speeds(4'd0, 4'd4, 4'd0);
        do_frame();
        check("b_rearm_bounce", {11'd0, bn_now[B]}, 12'd1);
        set_speeds(4'd0, 4'd0, 4'd0);
        any_bounce = 1'b0;
        for (int f = 0; f < 10; f++) begin
            do_frame();
            any_bounce = any_bounce | bn_now[B] | bn_after[B];
        end
        check("b_speed0_no_bounce", {11'd0, any_bounce}, 12'd0);
        probe(B, 10'd608, 10'd104, 12'h0F0, "b_speed0_x608");
        probe(B, 10'd607, 10'd104, BG,      "b_speed0_left_607");
        probe(B, 10'd608, 10'd448, 12'h00F, "b_speed0_corner");
        set_speeds(4'd0, 4'd4, 4'd0);
        do_frame();
        check("b_resume_no_bounce", {11'd0, bn_now[B]}, 12'd0);
        probe(B, 10'd604, 10'd108, 12'h0F0, "b_resume_dir_left");
        probe(B, 10'd603, 10'd108, BG,      "b_resume_left_603");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
